// File: rtl/stack2pipe_n.sv
// Parametrised j1a-style data/return stack: registered top-of-stack plus a DEPTH-entry circular array.
// Optional overflow/underflow suppression with sticky flags is enabled by defining STACK_GUARD_EN.
module stack2pipe_n #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         resetq,
    input  logic [WIDTH-1:0]             wd,
    input  logic                         we,
    input  logic [1:0]                   delta,
    input  logic                         clr_err,
    output logic [WIDTH-1:0]             rd,
    output logic [WIDTH-1:0]             nos,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [1:0] D_HOLD = 2'b00;
    localparam logic [1:0] D_PUSH = 2'b01;
    localparam logic [1:0] D_POP2 = 2'b10;
    localparam logic [1:0] D_POP  = 2'b11;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] t_q, t_n;
    logic [PW-1:0]    sp_q, sp_n;
    logic [CW-1:0]    depth_q, depth_n;
    logic             overflow_q, underflow_q;

    logic             mem_we;
    logic [PW-1:0]    mem_wa;
    logic             ovf_c, unf_c;

    // Guard conditions; without the guard they never fire and the array wraps like legacy j1a.
    always_comb begin
        ovf_c = 1'b0;
        unf_c = 1'b0;
`ifdef STACK_GUARD_EN
        ovf_c = (delta == D_PUSH) && (depth_q == CW'(DEPTH));
        unf_c = ((delta == D_POP)  && (depth_q == CW'(0))) ||
                ((delta == D_POP2) && (depth_q <  CW'(2)));
`endif
    end

    // Next state for T, sp, depth and the array write.
    always_comb begin
        t_n     = t_q;
        sp_n    = sp_q;
        depth_n = depth_q;
        mem_we  = 1'b0;
        mem_wa  = sp_q + PW'(1);
        if (!(ovf_c || unf_c)) begin
            case (delta)
                D_HOLD: begin
                    if (we) t_n = wd;
                end
                D_PUSH: begin
                    mem_we  = 1'b1;
                    sp_n    = sp_q + PW'(1);
                    t_n     = we ? wd : t_q;
                    depth_n = (depth_q == CW'(DEPTH)) ? depth_q : depth_q + CW'(1);
                end
                D_POP: begin
                    sp_n    = sp_q - PW'(1);
                    t_n     = we ? wd : mem[sp_q];
                    depth_n = (depth_q == CW'(0)) ? CW'(0) : depth_q - CW'(1);
                end
                D_POP2: begin
                    sp_n    = sp_q - PW'(2);
                    t_n     = we ? wd : mem[sp_q - PW'(1)];
                    depth_n = (depth_q < CW'(2)) ? CW'(0) : depth_q - CW'(2);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            t_q         <= '0;
            sp_q        <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            t_q         <= t_n;
            sp_q        <= sp_n;
            depth_q     <= depth_n;
            // A new error wins over a simultaneous clear.
            overflow_q  <= ovf_c | (overflow_q  & ~clr_err);
            underflow_q <= unf_c | (underflow_q & ~clr_err);
        end
    end

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= t_q;
    end

    assign rd        = t_q;
    assign nos       = mem[sp_q];
    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_stack2pipe_n.sv
// Directed self-checking bench for stack2pipe_n at WIDTH=16, DEPTH=4; follows STACK_GUARD_EN of the build.
module tb_stack2pipe_n;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             resetq = 1'b0;
    logic [WIDTH-1:0] wd = '0;
    logic             we = 1'b0;
    logic [1:0]       delta = 2'b00;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] nos;
    logic [2:0]       depth;
    logic             overflow;
    logic             underflow;

    int errors = 0;
    int checks = 0;

    stack2pipe_n #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetq(resetq), .wd(wd), .we(we), .delta(delta), .clr_err(clr_err),
        .rd(rd), .nos(nos), .depth(depth), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // One clocked operation; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic [1:0] d, input logic w, input logic [WIDTH-1:0] data, input logic clr);
        delta = d; we = w; wd = data; clr_err = clr;
        @(posedge clk);
        #1;
        delta = 2'b00; we = 1'b0; wd = '0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        delta = 2'b00; we = 1'b0; wd = '0; clr_err = 1'b0;
        resetq = 1'b0;
        @(posedge clk);
        #1;
        resetq = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL reset_rd: got %h want %h", rd, 16'h0000); end
        checks++; if (depth !== 3'd0) begin errors++; $display("FAIL reset_depth: got %0d want 0", depth); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b want 0", underflow); end
    endtask

    task automatic test_push_pop();
        do_reset();
        step(2'b01, 1'b1, 16'h0011, 1'b0);
        step(2'b01, 1'b1, 16'h0022, 1'b0);
        step(2'b01, 1'b1, 16'h0033, 1'b0);
        checks++; if (rd !== 16'h0033) begin errors++; $display("FAIL push3_rd: got %h want %h", rd, 16'h0033); end
        checks++; if (nos !== 16'h0022) begin errors++; $display("FAIL push3_nos: got %h want %h", nos, 16'h0022); end
        checks++; if (depth !== 3'd3) begin errors++; $display("FAIL push3_depth: got %0d want 3", depth); end
        step(2'b11, 1'b0, 16'h0000, 1'b0);
        checks++; if (rd !== 16'h0022) begin errors++; $display("FAIL pop_rd: got %h want %h", rd, 16'h0022); end
        checks++; if (nos !== 16'h0011) begin errors++; $display("FAIL pop_nos: got %h want %h", nos, 16'h0011); end
        checks++; if (depth !== 3'd2) begin errors++; $display("FAIL pop_depth: got %0d want 2", depth); end
        step(2'b10, 1'b0, 16'h0000, 1'b0);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL pop2_rd: got %h want %h", rd, 16'h0000); end
        checks++; if (depth !== 3'd0) begin errors++; $display("FAIL pop2_depth: got %0d want 0", depth); end
    endtask

    task automatic test_hold_dup();
        do_reset();
        step(2'b01, 1'b1, 16'h0011, 1'b0);
        step(2'b01, 1'b1, 16'h0022, 1'b0);
        step(2'b01, 1'b1, 16'h0033, 1'b0);
        step(2'b00, 1'b0, 16'h5555, 1'b0);
        checks++; if (rd !== 16'h0033) begin errors++; $display("FAIL hold_nowe_rd: got %h want %h", rd, 16'h0033); end
        step(2'b00, 1'b1, 16'hABCD, 1'b0);
        checks++; if (rd !== 16'hABCD) begin errors++; $display("FAIL hold_we_rd: got %h want %h", rd, 16'hABCD); end
        checks++; if (nos !== 16'h0022) begin errors++; $display("FAIL hold_we_nos: got %h want %h", nos, 16'h0022); end
        checks++; if (depth !== 3'd3) begin errors++; $display("FAIL hold_we_depth: got %0d want 3", depth); end
        step(2'b01, 1'b0, 16'h0000, 1'b0);
        checks++; if (rd !== 16'hABCD) begin errors++; $display("FAIL dup_rd: got %h want %h", rd, 16'hABCD); end
        checks++; if (nos !== 16'hABCD) begin errors++; $display("FAIL dup_nos: got %h want %h", nos, 16'hABCD); end
        checks++; if (depth !== 3'd4) begin errors++; $display("FAIL dup_depth: got %0d want 4", depth); end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] exp_pop [4];
        do_reset();
        for (int i = 1; i <= 4; i++) step(2'b01, 1'b1, 16'(i), 1'b0);
        checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL full_rd: got %h want %h", rd, 16'h0004); end
        checks++; if (depth !== 3'd4) begin errors++; $display("FAIL full_depth: got %0d want 4", depth); end
        step(2'b01, 1'b1, 16'h0005, 1'b0);
`ifdef STACK_GUARD_EN
        checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL ovf_rd: got %h want %h", rd, 16'h0004); end
        checks++; if (depth !== 3'd4) begin errors++; $display("FAIL ovf_depth: got %0d want 4", depth); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        step(2'b00, 1'b0, 16'h0000, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", overflow); end
        exp_pop[0] = 16'h0003; exp_pop[1] = 16'h0002; exp_pop[2] = 16'h0001; exp_pop[3] = 16'h0000;
`else
        checks++; if (rd !== 16'h0005) begin errors++; $display("FAIL wrap_rd: got %h want %h", rd, 16'h0005); end
        checks++; if (depth !== 3'd4) begin errors++; $display("FAIL wrap_depth: got %0d want 4", depth); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b want 0", overflow); end
        exp_pop[0] = 16'h0004; exp_pop[1] = 16'h0003; exp_pop[2] = 16'h0002; exp_pop[3] = 16'h0001;
`endif
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 1'b0, 16'h0000, 1'b0);
            checks++; if (rd !== exp_pop[i]) begin errors++; $display("FAIL drain_rd%0d: got %h want %h", i, rd, exp_pop[i]); end
        end
        checks++; if (depth !== 3'd0) begin errors++; $display("FAIL drain_depth: got %0d want 0", depth); end
    endtask

    task automatic test_underflow();
        do_reset();
        step(2'b11, 1'b1, 16'h1234, 1'b0);
`ifdef STACK_GUARD_EN
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL unf_pop_rd: got %h want %h", rd, 16'h0000); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_pop_flag: got %b want 1", underflow); end
        step(2'b01, 1'b1, 16'h0055, 1'b0);
        checks++; if (depth !== 3'd1) begin errors++; $display("FAIL unf_push_depth: got %0d want 1", depth); end
        step(2'b10, 1'b0, 16'h0000, 1'b0);
        checks++; if (rd !== 16'h0055) begin errors++; $display("FAIL unf_pop2_rd: got %h want %h", rd, 16'h0055); end
        checks++; if (depth !== 3'd1) begin errors++; $display("FAIL unf_pop2_depth: got %0d want 1", depth); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_pop2_flag: got %b want 1", underflow); end
        step(2'b11, 1'b0, 16'h0000, 1'b0);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL unf_legal_pop_rd: got %h want %h", rd, 16'h0000); end
        step(2'b11, 1'b0, 16'h0000, 1'b1);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_setwins: got %b want 1", underflow); end
        step(2'b00, 1'b0, 16'h0000, 1'b1);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clr: got %b want 0", underflow); end
`else
        checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL nog_pop_rd: got %h want %h", rd, 16'h1234); end
        checks++; if (depth !== 3'd0) begin errors++; $display("FAIL nog_pop_depth: got %0d want 0", depth); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL nog_pop_unf: got %b want 0", underflow); end
        step(2'b01, 1'b1, 16'h0055, 1'b0);
        checks++; if (rd !== 16'h0055) begin errors++; $display("FAIL nog_push_rd: got %h want %h", rd, 16'h0055); end
        checks++; if (nos !== 16'h1234) begin errors++; $display("FAIL nog_push_nos: got %h want %h", nos, 16'h1234); end
        checks++; if (depth !== 3'd1) begin errors++; $display("FAIL nog_push_depth: got %0d want 1", depth); end
        step(2'b10, 1'b0, 16'h0000, 1'b0);
        checks++; if (depth !== 3'd0) begin errors++; $display("FAIL nog_pop2_depth: got %0d want 0", depth); end
        step(2'b11, 1'b0, 16'h0000, 1'b1);
        checks++; if (depth !== 3'd0) begin errors++; $display("FAIL nog_pop_sat: got %0d want 0", depth); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL nog_unf_tied: got %b want 0", underflow); end
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(2'b01, 1'b1, 16'h0001, 1'b0);
        step(2'b01, 1'b1, 16'h0002, 1'b0);
        step(2'b01, 1'b1, 16'h0003, 1'b0);
        step(2'b10, 1'b1, 16'h0077, 1'b0);
        checks++; if (rd !== 16'h0077) begin errors++; $display("FAIL b2b_pop2we_rd: got %h want %h", rd, 16'h0077); end
        checks++; if (nos !== 16'h0000) begin errors++; $display("FAIL b2b_pop2we_nos: got %h want %h", nos, 16'h0000); end
        checks++; if (depth !== 3'd1) begin errors++; $display("FAIL b2b_pop2we_depth: got %0d want 1", depth); end
        step(2'b11, 1'b1, 16'h0088, 1'b0);
        checks++; if (rd !== 16'h0088) begin errors++; $display("FAIL b2b_popwe_rd: got %h want %h", rd, 16'h0088); end
        checks++; if (depth !== 3'd0) begin errors++; $display("FAIL b2b_popwe_depth: got %0d want 0", depth); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(2'b01, 1'b1, 16'h0010, 1'b0);
        step(2'b01, 1'b1, 16'h0020, 1'b0);
        delta = 2'b01; we = 1'b1; wd = 16'h0030;
        #2;
        resetq = 1'b0;
        #1;
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL arst_rd: got %h want %h", rd, 16'h0000); end
        checks++; if (depth !== 3'd0) begin errors++; $display("FAIL arst_depth: got %0d want 0", depth); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL arst_flags: got %b want 00", {overflow, underflow}); end
        @(posedge clk);
        #1;
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL arst_held_rd: got %h want %h", rd, 16'h0000); end
        delta = 2'b00; we = 1'b0; wd = '0;
        resetq = 1'b1;
        step(2'b01, 1'b1, 16'h0042, 1'b0);
        checks++; if (rd !== 16'h0042) begin errors++; $display("FAIL arst_push_rd: got %h want %h", rd, 16'h0042); end
        checks++; if (depth !== 3'd1) begin errors++; $display("FAIL arst_push_depth: got %0d want 1", depth); end
    endtask

    initial begin
        #3;
        test_reset();
        test_push_pop();
        test_hold_dup();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack2pipe_n.md
Name: stack2pipe_n

Overview:
Parametrised successor of the 4-deep pipelined data/return stack used by the j1a core. It provides a top-of-stack register plus a DEPTH-entry circular array, with a signed 2-bit stack delta that includes a new pop-two operation. It adds a next-on-stack read port, an occupancy counter, and optional overflow/underflow guarding with sticky error flags. It drops in wherever the core instantiates dstack/rstack.

Parameters:
WIDTH, 16, data word width in bits.
DEPTH, 16, array entries below top; power of two, >= 2; pointer width = $clog2(DEPTH).

Ports:
clk  input  1  system clock, all state updates on rising edge.
resetq  input  1  asynchronous, active-low reset.
wd  input  WIDTH  write data for top of stack.
we  input  1  top-of-stack write enable.
delta  input  2  stack move, two's complement: 00 hold, 01 push, 11 pop, 10 pop-two.
clr_err  input  1  clears the sticky error flags.
rd  output  WIDTH  top of stack (T), registered.
nos  output  WIDTH  next on stack, mem[sp], combinational from registers.
depth  output  $clog2(DEPTH+1)  valid entries in the array, excluding T.
overflow  output  1  sticky overflow flag.
underflow  output  1  sticky underflow flag.

Behaviour:
- Reset (resetq low, asynchronous): T=0, sp=0, depth=0, overflow=0, underflow=0. Array contents are not reset. nos is undefined while depth=0.
- Zero-latency read: rd and nos reflect state after the last edge. All updates take one cycle.
- Hold (00): T <= we ? wd : T. sp and depth unchanged.
- Push (01): mem[sp+1] <= T; sp <= sp+1; T <= we ? wd : T, so a push without we duplicates T. depth <= min(depth+1, DEPTH).
- Pop (11): T <= we ? wd : mem[sp]; sp <= sp-1; depth <= max(depth-1, 0).
- Pop-two (10): T <= we ? wd : mem[sp-1]; sp <= sp-2; depth <= max(depth-2, 0).
- sp arithmetic is modulo DEPTH (wraps).
- depth always saturates at 0 and DEPTH, independent of the guard.
- Flags: a set condition and clr_err in the same cycle leave the flag set (set wins). Otherwise clr_err clears both flags on the next edge.
- Reset mid-operation aborts the in-flight op. No partial update survives.

Optional Feature:
STACK_GUARD_EN
- Defined: a push at depth==DEPTH, a pop at depth==0, or a pop-two at depth<2 is suppressed entirely (T, sp, mem, depth unchanged, we ignored). The matching flag is set on that edge.
- Undefined: no suppression. sp wraps and the oldest entry is overwritten (circular, legacy j1a behaviour). overflow and underflow are tied to 0, and clr_err is ignored.

Test Plan:
All scenarios use WIDTH=16, DEPTH=4.
1. Release reset -> rd=0x0000, depth=0, overflow=0, underflow=0.
2. Push with we, wd=0x0011, 0x0022, 0x0033 -> rd=0x0033, nos=0x0022, depth=3. Pop, we=0 -> rd=0x0022, nos=0x0011, depth=2. Pop-two, we=0 -> rd=0x0000, depth=0.
3. Hold with we=1, wd=0xABCD after step 2's pushes -> rd=0xABCD, nos=0x0022, depth=3. Push, we=0 -> rd=0xABCD, nos=0xABCD, depth=4.
4. Guard on: five pushes of 1..5 from reset -> after the 4th, depth=4 and rd=4. The 5th leaves rd=4, depth=4, overflow=1. clr_err the next cycle -> overflow=0. Guard off, same stimulus -> rd=5, depth=4, overflow=0. Four pops then give rd=4,3,2,1 (the initial 0 was overwritten).
5. Guard on: pop at depth=0 with we=1, wd=0x1234 -> rd stays 0, underflow=1. Pop-two at depth=1 -> suppressed, underflow=1. Pop at depth=0 with clr_err=1 in the same cycle -> underflow stays 1.
6. Drive resetq low between clock edges mid-push sequence -> rd=0, depth=0, flags=0 immediately, with no clock edge. Release, then push 0x0042 -> rd=0x0042, depth=1.
